// File: rtl/fas_chk_pkg.sv
// Shared types and helpers for the streaming tolerance checker.
// Holds the FSM states, lane-width helper, modular tolerance compare and popcount.
package fas_chk_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        END  = 2'd2
    } state_t;

    function automatic int lane_width(input int dw, input int cplx);
        return dw * (1 + cplx);
    endfunction

    // Difference is taken modulo 2^dw and read as signed, so values wrap around the ends of the range.
    function automatic logic tol_ok(input logic [63:0] dut, input logic [63:0] gold,
                                    input logic [63:0] tol, input int dw);
        logic [63:0] mask;
        logic [63:0] diff;
        logic [63:0] mag;
        mask = (64'd1 << dw) - 64'd1;
        diff = (dut - gold) & mask;
        if (((diff >> (dw - 1)) & 64'd1) != 64'd0)
            mag = (~diff + 64'd1) & mask;
        else
            mag = diff;
        return (mag <= tol);
    endfunction

    function automatic int popcount(input logic [63:0] v);
        int n;
        n = 0;
        for (int i = 0; i < 64; i++)
            n = n + int'(v[i]);
        return n;
    endfunction

endpackage

// File: rtl/chk_sync_fifo.sv
// Small synchronous FIFO for golden beats; flush empties it in one cycle.
// No read bypass: a beat written this cycle is visible to pops from the next cycle on.
module chk_sync_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wr;
    logic [AW:0]  r_rd;
    logic         w_do_push;
    logic         w_do_pop;

    assign empty     = (r_wr == r_rd);
    assign full      = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);
    assign dout      = r_mem[r_rd[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr <= '0;
            r_rd <= '0;
        end else if (flush) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (w_do_push) r_wr <= r_wr + 1'b1;
            if (w_do_pop)  r_rd <= r_rd + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !flush)
            r_mem[r_wr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/stream_tol_checker.sv
// Compares a multi-lane DUT stream against buffered golden beats with a modular +/-TOL window,
// counting failed points and ending the run on completion, fail limit or underrun.
module stream_tol_checker
    import fas_chk_pkg::*;
#(
    parameter int LANES      = 16,
    parameter int DW         = 16,
    parameter int CPLX       = 1,
    parameter int TOL        = 3,
    parameter int FAIL_LIMIT = 48,
    parameter int EXP_COUNT  = 1024,
    parameter int DEPTH      = 4,
    parameter int CNT_W      = 16
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    input  logic                                   dut_valid,
    input  logic [LANES*lane_width(DW, CPLX)-1:0]  dut_data,
    input  logic                                   gold_valid,
    output logic                                   gold_ready,
    input  logic [LANES*lane_width(DW, CPLX)-1:0]  gold_data,
    output logic [LANES-1:0]                       fail_mask,
    output logic [CNT_W-1:0]                       fail_cnt,
    output logic [CNT_W-1:0]                       point_cnt,
    output logic [CNT_W-1:0]                       first_fail_idx,
    output logic                                   first_fail_vld,
    output logic                                   underrun,
    output logic                                   done,
    output logic                                   pass,
    output logic                                   abort
);
    localparam int LW  = lane_width(DW, CPLX);
    localparam int BW  = LANES * LW;
    localparam int NC  = 1 + CPLX;
    localparam int CW1 = CNT_W + 1;

    state_t           r_state;
    logic [LANES-1:0] r_fail_mask;
    logic [CNT_W-1:0] r_fail_cnt;
    logic [CNT_W-1:0] r_point_cnt;
    logic [CNT_W-1:0] r_ff_idx;
    logic             r_ff_vld;
    logic             r_underrun;
    logic             r_done;
    logic             r_pass;
    logic             r_abort;

    logic [BW-1:0]    w_gold;
    logic             w_full;
    logic             w_empty;
    logic             w_cmp;
    logic             w_under;
    logic [LANES-1:0] w_mask;
    logic [CNT_W-1:0] w_first;
    logic [CNT_W:0]   w_fail_sum;
    logic [CNT_W-1:0] w_fail_next;
    logic [CNT_W:0]   w_point_sum;
    logic             w_abort;
    logic             w_complete;

    assign gold_ready = (r_state == RUN) && !w_full;
    assign w_cmp      = dut_valid && (r_state == RUN);
    assign w_under    = w_cmp && w_empty;

    chk_sync_fifo #(
        .W     (BW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (start && (r_state != RUN)),
        .push  (gold_valid && gold_ready),
        .pop   (w_cmp),
        .din   (gold_data),
        .dout  (w_gold),
        .full  (w_full),
        .empty (w_empty)
    );

    // An underrun beat has no golden partner, so every lane of it is charged as a failure.
    always_comb begin
        w_mask  = '0;
        w_first = '0;
        if (w_empty) begin
            w_mask = '1;
        end else begin
            for (int l = 0; l < LANES; l++)
                for (int c = 0; c < NC; c++)
                    if (!tol_ok(64'(dut_data[l*LW + c*DW +: DW]), 64'(w_gold[l*LW + c*DW +: DW]),
                                64'(TOL), DW))
                        w_mask[l] = 1'b1;
        end
        for (int l = LANES - 1; l >= 0; l--)
            if (w_mask[l]) w_first = CNT_W'(l);
    end

    assign w_fail_sum  = {1'b0, r_fail_cnt} + CW1'(popcount(64'(w_mask)));
    assign w_fail_next = w_fail_sum[CNT_W] ? '1 : w_fail_sum[CNT_W-1:0];
    assign w_point_sum = {1'b0, r_point_cnt} + CW1'(LANES);
    assign w_abort     = ({1'b0, w_fail_next} >= CW1'(FAIL_LIMIT)) || w_under;
    assign w_complete  = (w_point_sum == CW1'(EXP_COUNT));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_fail_mask <= '0;
            r_fail_cnt  <= '0;
            r_point_cnt <= '0;
            r_ff_idx    <= '0;
            r_ff_vld    <= 1'b0;
            r_underrun  <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_abort     <= 1'b0;
        end else begin
            case (r_state)
                IDLE, END: begin
                    if (start) begin
                        r_state     <= RUN;
                        r_fail_mask <= '0;
                        r_fail_cnt  <= '0;
                        r_point_cnt <= '0;
                        r_ff_idx    <= '0;
                        r_ff_vld    <= 1'b0;
                        r_underrun  <= 1'b0;
                        r_done      <= 1'b0;
                        r_pass      <= 1'b0;
                        r_abort     <= 1'b0;
                    end
                end
                RUN: begin
                    if (dut_valid) begin
                        r_fail_mask <= w_mask;
                        r_fail_cnt  <= w_fail_next;
                        r_point_cnt <= w_point_sum[CNT_W-1:0];
                        if (|w_mask && !r_ff_vld) begin
                            r_ff_idx <= r_point_cnt + w_first;
                            r_ff_vld <= 1'b1;
                        end
                        if (w_under) r_underrun <= 1'b1;
                        // Abort wins over completion when both land on the same beat.
                        if (w_abort) begin
                            r_state <= END;
                            r_done  <= 1'b1;
                            r_abort <= 1'b1;
                            r_pass  <= 1'b0;
                        end else if (w_complete) begin
                            r_state <= END;
                            r_done  <= 1'b1;
                            r_pass  <= (w_fail_next == '0) && !r_underrun;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign fail_mask      = r_fail_mask;
    assign fail_cnt       = r_fail_cnt;
    assign point_cnt      = r_point_cnt;
    assign first_fail_idx = r_ff_idx;
    assign first_fail_vld = r_ff_vld;
    assign underrun       = r_underrun;
    assign done           = r_done;
    assign pass           = r_pass;
    assign abort          = r_abort;

endmodule
